mixer_gain_axil_slave: RTL and testbench

MIXER_GAIN_AXIL_SLAVE -- requirements
Module: mixer_gain_axil_slave

---
 rtl/mixer_gain_axil_slave_if.sv | 36 +++
 rtl/mixer_gain_axil_slave.sv | 118 +++++++++++
 tb/tb_mixer_gain_axil_slave.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mixer_gain_axil_slave_if.sv
// mixer_gain_axil_slave_if: AXI4-Lite bus bundle between a register master and the mixer gain slave
interface mixer_gain_axil_slave_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic [2:0]            S_AXI_AWPROT;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [31:0]           S_AXI_WDATA;
    logic [3:0]            S_AXI_WSTRB;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic [2:0]            S_AXI_ARPROT;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [31:0]           S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;
    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/mixer_gain_axil_slave.sv
// mixer_gain_axil_slave: AXI4-Lite slave holding four Q16.16 mixer gains plus a read-only ID word.
// Optional macro MIXER_AXIL_SLVERR_EN: SLVERR for ID/unmapped writes and unmapped reads.
module mixer_gain_axil_slave #(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [31:0] ID_VALUE   = 32'h4D4E5631
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    mixer_gain_axil_slave_if.slave s_axi,
    output logic [127:0]           gain,
    output logic [3:0]             gain_upd
);
    localparam logic [31:0] GAIN_UNITY = 32'h0001_0000;
    localparam logic [1:0]  OKAY       = 2'b00;
`ifdef MIXER_AXIL_SLVERR_EN
    localparam logic [1:0]  ERR_RESP   = 2'b10;
`else
    localparam logic [1:0]  ERR_RESP   = 2'b00;
`endif
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic                  live_q, live_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [2:0]            aw_word_q, aw_word_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [3:0][31:0]      gain_q, gain_d;
    logic [3:0]            gain_upd_q, gain_upd_d;
    logic                  awready, wready, arready;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [2:0]            wr_word, rd_word;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  unused;
    assign aw_addr = s_axi.S_AXI_AWADDR;
    assign ar_addr = s_axi.S_AXI_ARADDR;
    assign unused  = ^{aw_addr, ar_addr, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};
    // live_q keeps the ready outputs low until the first edge after reset release
    assign awready = live_q && !aw_held_q && !bvalid_q;
    assign wready  = live_q && !w_held_q && !bvalid_q;
    assign arready = live_q && !rvalid_q;
    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign gain     = gain_q;
    assign gain_upd = gain_upd_q;
    always_comb begin
        live_d     = 1'b1;
        aw_hs      = s_axi.S_AXI_AWVALID && awready;
        w_hs       = s_axi.S_AXI_WVALID && wready;
        wr_word    = aw_hs ? aw_addr[4:2] : aw_word_q;
        wr_data    = w_hs ? s_axi.S_AXI_WDATA : wdata_q;
        wr_strb    = w_hs ? s_axi.S_AXI_WSTRB : wstrb_q;
        commit     = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        aw_held_d  = (aw_held_q || aw_hs) && !commit;
        w_held_d   = (w_held_q || w_hs) && !commit;
        aw_word_d  = wr_word;
        wdata_d    = wr_data;
        wstrb_d    = wr_strb;
        bvalid_d   = commit || (bvalid_q && !s_axi.S_AXI_BREADY);
        bresp_d    = commit ? (wr_word[2] ? ERR_RESP : OKAY) : bresp_q;
        gain_d     = gain_q;
        gain_upd_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (commit && wr_word == 3'(i)) begin
                gain_upd_d[i] = 1'b1;
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) gain_d[i][8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        // reads sample gain_q, so a coincident write returns the pre-write value
        ar_hs    = s_axi.S_AXI_ARVALID && arready;
        rd_word  = ar_addr[4:2];
        rvalid_d = ar_hs || (rvalid_q && !s_axi.S_AXI_RREADY);
        rdata_d  = !ar_hs ? rdata_q :
                   !rd_word[2] ? gain_q[rd_word[1:0]] :
                   rd_word == 3'd4 ? ID_VALUE : 32'h0;
        rresp_d  = !ar_hs ? rresp_q : rd_word > 3'd4 ? ERR_RESP : OKAY;
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            live_q     <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_word_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
            gain_q     <= {4{GAIN_UNITY}};
            gain_upd_q <= '0;
        end else begin
            live_q     <= live_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_word_q  <= aw_word_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            gain_q     <= gain_d;
            gain_upd_q <= gain_upd_d;
        end
    end
endmodule

// File: tb/tb_mixer_gain_axil_slave.sv
// tb_mixer_gain_axil_slave: randomized AXI4-Lite traffic checked against a register-map model
module tb_mixer_gain_axil_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    mixer_gain_axil_slave_if #(.ADDR_WIDTH(5)) bus ();
    logic [127:0] gain;
    logic [3:0]   gain_upd;
    mixer_gain_axil_slave #(.ADDR_WIDTH(5), .ID_VALUE(32'h4D4E5631)) dut (
        .ACLK(clk), .ARESETN(rst_n), .s_axi(bus), .gain(gain), .gain_upd(gain_upd)
    );
`ifdef MIXER_AXIL_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif
    int checks = 0;
    int errors = 0;
    logic [31:0] m_gain [4];
    logic [3:0]  exp_upd = 4'b0;
    bit          cmp_en = 1'b0;
    logic [31:0] rd;
    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [31:0] m_read(int w);
        return w < 4 ? m_gain[w] : w == 4 ? 32'h4D4E5631 : 32'h0;
    endfunction
    function automatic logic [1:0] m_rresp(int w);
        return w > 4 ? ERR : 2'b00;
    endfunction
    function automatic logic [1:0] m_bresp(int w);
        return w >= 4 ? ERR : 2'b00;
    endfunction
    task automatic m_write(int w, logic [31:0] data, logic [3:0] strb);
        if (w < 4)
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_gain[w][8*b +: 8] = data[8*b +: 8];
        exp_upd = w < 4 ? 4'(1 << w) : 4'b0;
    endtask
    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_gain[i] = 32'h0001_0000;
        exp_upd = 4'b0;
    endtask
    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            chk("gain", gain, {m_gain[3], m_gain[2], m_gain[1], m_gain[0]});
            chk("gain_upd", 128'(gain_upd), 128'(exp_upd));
            exp_upd = 4'b0;
        end
    end
    task automatic axi_write(logic [4:0] addr, logic [31:0] data, logic [3:0] strb, int da, int dw, int hold);
        bit awd = 0;
        bit wd = 0;
        int w = int'(addr[4:2]);
        bus.S_AXI_AWADDR = addr;
        bus.S_AXI_AWPROT = 3'($urandom);
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = strb;
        for (int c = 0; !(awd && wd); c++) begin
            if (c > 40) begin
                chk("write_timeout", 1, 0);
                break;
            end
            @(negedge clk);
            if (awd) chk("awready_held", 128'(bus.S_AXI_AWREADY), 0);
            if (wd) chk("wready_held", 128'(bus.S_AXI_WREADY), 0);
            bus.S_AXI_AWVALID = !awd && c >= da;
            bus.S_AXI_WVALID  = !wd && c >= dw;
            if (bus.S_AXI_AWVALID) begin
                chk("awready", 128'(bus.S_AXI_AWREADY), 1);
                awd = bus.S_AXI_AWREADY;
            end
            if (bus.S_AXI_WVALID) begin
                chk("wready", 128'(bus.S_AXI_WREADY), 1);
                wd = bus.S_AXI_WREADY;
            end
            if (awd && wd) m_write(w, data, strb);
        end
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        chk("bvalid", 128'(bus.S_AXI_BVALID), 1);
        chk("bresp", 128'(bus.S_AXI_BRESP), 128'(m_bresp(w)));
        repeat (hold) begin
            @(negedge clk);
            chk("bvalid_hold", 128'(bus.S_AXI_BVALID), 1);
            chk("bresp_hold", 128'(bus.S_AXI_BRESP), 128'(m_bresp(w)));
            chk("awready_stall", 128'(bus.S_AXI_AWREADY), 0);
            chk("wready_stall", 128'(bus.S_AXI_WREADY), 0);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        chk("bvalid_clear", 128'(bus.S_AXI_BVALID), 0);
        chk("awready_idle", 128'(bus.S_AXI_AWREADY), 1);
    endtask
    task automatic axi_read(logic [4:0] addr, int hold, output logic [31:0] data);
        int w = int'(addr[4:2]);
        logic [31:0] e;
        logic [1:0]  er;
        e  = m_read(w);
        er = m_rresp(w);
        @(negedge clk);
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARPROT  = 3'($urandom);
        bus.S_AXI_ARVALID = 1'b1;
        chk("arready", 128'(bus.S_AXI_ARREADY), 1);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        data = bus.S_AXI_RDATA;
        chk("rvalid", 128'(bus.S_AXI_RVALID), 1);
        chk("rdata", 128'(bus.S_AXI_RDATA), 128'(e));
        chk("rresp", 128'(bus.S_AXI_RRESP), 128'(er));
        repeat (hold) begin
            @(negedge clk);
            chk("rvalid_hold", 128'(bus.S_AXI_RVALID), 1);
            chk("rdata_hold", 128'(bus.S_AXI_RDATA), 128'(e));
            chk("rresp_hold", 128'(bus.S_AXI_RRESP), 128'(er));
            chk("arready_stall", 128'(bus.S_AXI_ARREADY), 0);
        end
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
        chk("rvalid_clear", 128'(bus.S_AXI_RVALID), 0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] old;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_awready", 128'(bus.S_AXI_AWREADY), 0);
        chk("rst_wready", 128'(bus.S_AXI_WREADY), 0);
        chk("rst_arready", 128'(bus.S_AXI_ARREADY), 0);
        chk("rst_bvalid", 128'(bus.S_AXI_BVALID), 0);
        chk("rst_rvalid", 128'(bus.S_AXI_RVALID), 0);
        chk("rst_rdata", 128'(bus.S_AXI_RDATA), 0);
        chk("rst_gain", gain, {4{32'h0001_0000}});
        chk("rst_gain_upd", 128'(gain_upd), 0);
        rst_n = 1'b1;
        #1;
        chk("release_awready", 128'(bus.S_AXI_AWREADY), 0);
        chk("release_arready", 128'(bus.S_AXI_ARREADY), 0);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("live_awready", 128'(bus.S_AXI_AWREADY), 1);
        chk("live_wready", 128'(bus.S_AXI_WREADY), 1);
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
            chk("lit_gain", 128'(gain[32*i +: 32]), 128'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), 0, rd);
            chk("lit_readback", 128'(rd), 128'(i + 1));
        end
        axi_write(5'h04, 32'hDEADBEEF, 4'hF, 3, 0, 0);
        chk("lit_gain1", 128'(gain[63:32]), 128'(32'hDEADBEEF));
        axi_write(5'h00, 32'h11223344, 4'hF, 1, 2, 1);
        axi_write(5'h00, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        axi_read(5'h00, 0, rd);
        chk("lit_strb", 128'(rd), 128'(32'h11BB33DD));
        axi_read(5'h10, 0, rd);
        chk("lit_id", 128'(rd), 128'(32'h4D4E5631));
        axi_write(5'h10, 32'h12345678, 4'hF, 0, 0, 0);
        axi_read(5'h10, 0, rd);
        chk("lit_id_after_write", 128'(rd), 128'(32'h4D4E5631));
        axi_read(5'h14, 0, rd);
        chk("lit_unmapped", 128'(rd), 0);
        axi_write(5'h08, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
        axi_write(5'h0C, 32'hCAFEF00D, 4'hF, 0, 2, 10);
        axi_read(5'h0E, 10, rd);
        @(negedge clk);
        old = m_read(2);
        bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_WDATA = 32'h0BADF00D; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 5'h08;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        chk("co_awready", 128'(bus.S_AXI_AWREADY), 1);
        chk("co_wready", 128'(bus.S_AXI_WREADY), 1);
        chk("co_arready", 128'(bus.S_AXI_ARREADY), 1);
        m_write(2, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        chk("co_bvalid", 128'(bus.S_AXI_BVALID), 1);
        chk("co_rvalid", 128'(bus.S_AXI_RVALID), 1);
        chk("co_rdata_old", 128'(bus.S_AXI_RDATA), 128'(old));
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        chk("co_bclear", 128'(bus.S_AXI_BVALID), 0);
        chk("co_rclear", 128'(bus.S_AXI_RVALID), 0);
        for (int n = 0; n < 80; n++) begin
            logic [4:0] a;
            a = 5'($urandom);
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 2), rd);
        end
        @(negedge clk);
        bus.S_AXI_AWADDR = 5'h04; bus.S_AXI_WDATA = 32'h55AA55AA; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        m_write(1, 32'h55AA55AA, 4'hF);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        chk("pre_reset_bvalid", 128'(bus.S_AXI_BVALID), 1);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_bvalid", 128'(bus.S_AXI_BVALID), 0);
        chk("async_gain", gain, {4{32'h0001_0000}});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_b_after_reset", 128'(bus.S_AXI_BVALID), 0);
        end
        axi_read(5'h04, 0, rd);
        chk("lit_unity_after_reset", 128'(rd), 128'(32'h0001_0000));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
